// File: rtl/phvl_pkg.sv
// Shared constants, state encoding and frame packing for the phase-value serializer.
// Defining PHVL_SER_PARITY_EN appends an even-parity bit to every element word.
package phvl_pkg;

  localparam int PHASE_W  = 5;
  localparam int NUM_ELEM = 5;

`ifdef PHVL_SER_PARITY_EN
  localparam int WORD_W = PHASE_W + 1;
`else
  localparam int WORD_W = PHASE_W;
`endif

  localparam int FRAME_N = NUM_ELEM * WORD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // eouts is {eout5, ..., eout1}; element 5 lands in the MSBs so it leaves first.
  function automatic logic [FRAME_N-1:0] build_frame(input logic [NUM_ELEM*PHASE_W-1:0] eouts);
    logic [FRAME_N-1:0] f;
    logic [PHASE_W-1:0] w;
    f = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      w = eouts[(NUM_ELEM-1-i)*PHASE_W +: PHASE_W];
`ifdef PHVL_SER_PARITY_EN
      f[FRAME_N-1-i*WORD_W -: WORD_W] = {w, ^w};
`else
      f[FRAME_N-1-i*WORD_W -: WORD_W] = w;
`endif
    end
    return f;
  endfunction

endpackage

// File: rtl/phvl_serializer_if.sv
// Load/phase-code bus and serial/status outputs of the phase-value serializer.
interface phvl_serializer_if;
  import phvl_pkg::*;

  logic               load;
  logic [PHASE_W-1:0] eout1;
  logic [PHASE_W-1:0] eout2;
  logic [PHASE_W-1:0] eout3;
  logic [PHASE_W-1:0] eout4;
  logic [PHASE_W-1:0] eout5;
  logic               sdata;
  logic               sclk;
  logic               slatch;
  logic               busy;
  logic               done;
  logic               overrun;

  modport master (
    output load, eout1, eout2, eout3, eout4, eout5,
    input  sdata, sclk, slatch, busy, done, overrun
  );

  modport slave (
    input  load, eout1, eout2, eout3, eout4, eout5,
    output sdata, sclk, slatch, busy, done, overrun
  );

endinterface

// File: rtl/phvl_clkdiv.sv
// Divider tick generator: one-cycle tick every CLK_DIV cycles, held at zero while cleared.
module phvl_clkdiv #(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tick = !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/phvl_serializer.sv
// Captures five element phase codes on load and shifts them MSB-first into the device chain,
// then pulses the latch strobe. PHVL_SER_PARITY_EN adds a parity bit per word (N = 30).
module phvl_serializer
  import phvl_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic             sys_clk,
  input  logic             rst,
  phvl_serializer_if.slave bus
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_N - 1);

  state_t             r_state;
  logic [FRAME_N-1:0] r_frame;
  logic [4:0]         r_bit;
  logic               r_phase;
  logic               r_sdata;
  logic               r_sclk;
  logic               r_slatch;
  logic               r_busy;
  logic               r_done;
  logic               r_overrun;

  logic               w_tick;
  logic               w_clr;
  logic [FRAME_N-1:0] w_frame;

  assign w_clr   = (r_state == IDLE);
  assign w_frame = build_frame({bus.eout5, bus.eout4, bus.eout3, bus.eout2, bus.eout1});

  phvl_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .sys_clk (sys_clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  // r_phase selects the half of the current bit (or latch pulse): 0 = first, 1 = second.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_frame   <= '0;
      r_bit     <= '0;
      r_phase   <= 1'b0;
      r_sdata   <= 1'b0;
      r_sclk    <= 1'b0;
      r_slatch  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sclk   <= 1'b0;
          r_slatch <= 1'b0;
          r_sdata  <= 1'b0;
          if (bus.load) begin
            r_frame <= w_frame;
            r_sdata <= w_frame[FRAME_N-1];
            r_bit   <= '0;
            r_phase <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_overrun <= bus.load;
          if (w_tick) begin
            if (!r_phase) begin
              r_sclk  <= 1'b1;
              r_phase <= 1'b1;
            end else begin
              r_sclk  <= 1'b0;
              r_phase <= 1'b0;
              if (r_bit == LAST_BIT) begin
                r_sdata  <= 1'b0;
                r_slatch <= 1'b1;
                r_state  <= LATCH;
              end else begin
                // Next bit sits one below the MSB of the not-yet-shifted frame.
                r_sdata <= r_frame[FRAME_N-2];
                r_frame <= r_frame << 1;
                r_bit   <= r_bit + 5'd1;
              end
            end
          end
        end
        LATCH: begin
          r_overrun <= bus.load;
          if (w_tick) begin
            if (!r_phase) begin
              r_phase <= 1'b1;
            end else begin
              r_phase  <= 1'b0;
              r_slatch <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sdata   = r_sdata;
  assign bus.sclk    = r_sclk;
  assign bus.slatch  = r_slatch;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_phvl_serializer.sv
// Directed bench for phvl_serializer: cycle-exact timing model plus a bit scoreboard per DUT.
module tb_phvl_serializer;

`ifdef PHVL_SER_PARITY_EN
  localparam int N = 30;
`else
  localparam int N = 25;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phvl_serializer_if ifa();
  phvl_serializer_if ifb();

  phvl_serializer #(.CLK_DIV(2)) dut_a (.sys_clk(clk), .rst(rst), .bus(ifa.slave));
  phvl_serializer #(.CLK_DIV(1)) dut_b (.sys_clk(clk), .rst(rst), .bus(ifb.slave));

  int   checks = 0;
  int   errors = 0;
  logic qa[$];
  logic qb[$];
  logic pa = 1'b0;
  logic pb = 1'b0;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int outs(input int which);
    if (which == 0)
      return int'({ifa.sdata, ifa.sclk, ifa.slatch, ifa.busy, ifa.done, ifa.overrun});
    return int'({ifb.sdata, ifb.sclk, ifb.slatch, ifb.busy, ifb.done, ifb.overrun});
  endfunction

  // Scoreboard: each sclk rising edge consumes one expected bit.
  always @(negedge clk) begin
    if (ifa.sclk && !pa) begin
      checks++;
      assert (qa.size() > 0) else begin
        errors++;
        $error("FAIL a_extra_bit observed=%0d expected=>0 queued", qa.size());
      end
      if (qa.size() > 0) chk_bit("a_sdata", ifa.sdata, qa.pop_front());
    end
    if (ifb.sclk && !pb) begin
      checks++;
      assert (qb.size() > 0) else begin
        errors++;
        $error("FAIL b_extra_bit observed=%0d expected=>0 queued", qb.size());
      end
      if (qb.size() > 0) chk_bit("b_sdata", ifb.sdata, qb.pop_front());
    end
    pa = ifa.sclk;
    pb = ifb.sclk;
  end

  task automatic push_frame(input int which, input logic [4:0] e5, e4, e3, e2, e1);
    logic [4:0] w [5];
    logic       p;
    w[0] = e5; w[1] = e4; w[2] = e3; w[3] = e2; w[4] = e1;
    for (int i = 0; i < 5; i++) begin
      p = 1'b0;
      for (int b = 4; b >= 0; b--) begin
        p = p ^ w[i][b];
        if (which == 0) qa.push_back(w[i][b]); else qb.push_back(w[i][b]);
      end
`ifdef PHVL_SER_PARITY_EN
      if (which == 0) qa.push_back(p); else qb.push_back(p);
`endif
    end
  endtask

  task automatic drive(input int which, input logic ld, input logic [4:0] e5, e4, e3, e2, e1);
    if (which == 0) begin
      ifa.load = ld; ifa.eout5 = e5; ifa.eout4 = e4; ifa.eout3 = e3; ifa.eout2 = e2; ifa.eout1 = e1;
    end else begin
      ifb.load = ld; ifb.eout5 = e5; ifb.eout4 = e4; ifb.eout3 = e3; ifb.eout2 = e2; ifb.eout1 = e1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rel = cycles since the cycle in which load was sampled.
  task automatic check_cycle(input int which, input int rel, input int d, input logic ov);
    int   t;
    int   o;
    logic e_sclk, e_slatch, e_busy, e_done;
    t        = rel - 1;
    o        = outs(which);
    e_busy   = (t < (2*N+2)*d);
    e_sclk   = (t < 2*N*d) && (((t / d) % 2) == 1);
    e_slatch = (t >= 2*N*d) && (t < (2*N+2)*d);
    e_done   = (t == (2*N+2)*d);
    chk_bit($sformatf("w%0d_sclk@%0d", which, rel), o[4], e_sclk);
    chk_bit($sformatf("w%0d_slatch@%0d", which, rel), o[3], e_slatch);
    chk_bit($sformatf("w%0d_busy@%0d", which, rel), o[2], e_busy);
    chk_bit($sformatf("w%0d_done@%0d", which, rel), o[1], e_done);
    chk_bit($sformatf("w%0d_overrun@%0d", which, rel), o[0], ov);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    drive(1, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    repeat (3) step();
    chk_int("reset_outs_a", outs(0), 0);
    chk_int("reset_outs_b", outs(1), 0);
    rst = 1'b0;

    // Idle after reset release
    for (int i = 0; i < 20; i++) begin
      step();
      chk_int($sformatf("idle_a@%0d", i), outs(0), 0);
      chk_int($sformatf("idle_b@%0d", i), outs(1), 0);
    end

    // Frame with CLK_DIV=2 plus an ignored load at cycle 50
    drive(0, 1'b1, 5'h1F, 5'h00, 5'h15, 5'h0A, 5'h01);
    push_frame(0, 5'h1F, 5'h00, 5'h15, 5'h0A, 5'h01);
    step();
    for (int rel = 1; rel <= (2*N+2)*2 + 2; rel++) begin
      check_cycle(0, rel, 2, rel == 51);
      if (rel == 2*N*2 + 1) chk_bit("slatch_rise", ifa.slatch, 1'b1);
      if (rel == (2*N+2)*2 + 1) chk_bit("done_pulse", ifa.done, 1'b1);
      if (rel == 50) drive(0, 1'b1, 5'h1B, 5'h1B, 5'h1B, 5'h1B, 5'h1B);
      else drive(0, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
      step();
    end
    chk_int("frame1_bits_left", qa.size(), 0);

    // Reset mid-frame at cycle 40, then a fresh frame
    drive(0, 1'b1, 5'h13, 5'h0C, 5'h1A, 5'h05, 5'h11);
    push_frame(0, 5'h13, 5'h0C, 5'h1A, 5'h05, 5'h11);
    step();
    for (int rel = 1; rel < 40; rel++) begin
      check_cycle(0, rel, 2, 1'b0);
      drive(0, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
      step();
    end
    rst = 1'b1;
    #1;
    chk_int("midframe_reset_outs", outs(0), 0);
    qa.delete();
    repeat (2) step();
    rst = 1'b0;
    step();
    chk_int("post_reset_idle", outs(0), 0);
    drive(0, 1'b1, 5'h0E, 5'h19, 5'h03, 5'h1C, 5'h06);
    push_frame(0, 5'h0E, 5'h19, 5'h03, 5'h1C, 5'h06);
    step();
    for (int rel = 1; rel <= (2*N+2)*2 + 2; rel++) begin
      check_cycle(0, rel, 2, 1'b0);
      drive(0, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
      step();
    end
    chk_int("frame_after_reset_bits_left", qa.size(), 0);

    // CLK_DIV=1 back-to-back frames, second load in the first done cycle
    drive(1, 1'b1, 5'h0F, 5'h0F, 5'h0F, 5'h0F, 5'h0F);
    push_frame(1, 5'h0F, 5'h0F, 5'h0F, 5'h0F, 5'h0F);
    step();
    for (int rel = 1; rel <= 2*N+3; rel++) begin
      check_cycle(1, rel, 1, 1'b0);
      if (rel == 2*N+3) begin
        drive(1, 1'b1, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10);
        push_frame(1, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10);
      end else begin
        drive(1, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
      end
      step();
    end
    for (int rel = 1; rel <= 2*N+4; rel++) begin
      check_cycle(1, rel, 1, 1'b0);
      drive(1, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
      step();
    end
    chk_int("b2b_bits_left", qb.size(), 0);

`ifdef PHVL_SER_PARITY_EN
    // Parity frame: first word 00111 + parity 1, all other words and parities 0
    drive(0, 1'b1, 5'h07, 5'h00, 5'h00, 5'h00, 5'h00);
    qa.push_back(1'b0); qa.push_back(1'b0); qa.push_back(1'b1);
    qa.push_back(1'b1); qa.push_back(1'b1); qa.push_back(1'b1);
    for (int i = 0; i < 24; i++) qa.push_back(1'b0);
    step();
    for (int rel = 1; rel <= 126; rel++) begin
      check_cycle(0, rel, 2, 1'b0);
      if (rel == 125) chk_bit("parity_done_125", ifa.done, 1'b1);
      drive(0, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
      step();
    end
    chk_int("parity_bits_left", qa.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phvl_serializer.md
# phvl_serializer

Downstream stage of the phase-value lookup block. It captures the five 5-bit element phase codes (eout1..eout5) on a load strobe and shifts them serially into the daisy-chained phase-shifter devices. Serial clock and latch strobe are generated from sys_clk. The block also reports busy, done and overrun status to the beam-steering controller.

## Interface
Parameters:
- CLK_DIV, default 2: sys_clk cycles per sclk half-period. Legal range 1..255.

Ports:
- sys_clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- load, input, 1: capture strobe. Driven from the same enable (flagf) that qualifies the LUT outputs.
- eout1..eout5, input, 5 each: element phase codes, stable while load is high.
- sdata, output, 1: serial data to the device chain.
- sclk, output, 1: serial clock. Devices sample on its rising edge.
- slatch, output, 1: latch strobe. Devices transfer their shift register to the outputs while it is high.
- busy, output, 1: high from the cycle after an accepted load until done.
- done, output, 1: one-cycle pulse when a frame is complete.
- overrun, output, 1: one-cycle pulse when load arrives while busy.

## Operation
- Frame: element 5 word first, element 1 word last (element 1 is nearest the FPGA in the chain). Each word is shifted MSB first.
- Without parity, N = 25 bits per frame.
- State machine:
  - IDLE: sclk=0, slatch=0, sdata=0. On load, capture eout1..eout5 into a shadow register and go to SHIFT.
  - SHIFT: bit counter runs 0..N-1. Divider tick period is CLK_DIV cycles. The sclk phases are low, then high, per bit. sdata changes only together with sclk falling, or on SHIFT entry. After the falling edge of bit N-1, go to LATCH.
  - LATCH: slatch=1 for 2*CLK_DIV cycles, sdata=0. Then go to IDLE, pulsing done in the same cycle.
- load while in SHIFT or LATCH is ignored: the shadow register is unchanged and overrun pulses the next cycle.
- Only the state where load is sampled matters: a load in the cycle in which done pulses is accepted, because the state is already IDLE.
- Inputs eout* are not sampled outside the load cycle.
- Counter widths: bit counter 5 bits; divider counter 8 bits. The divider counts 0..CLK_DIV-1 and wraps to 0 on tick.

## Timing
- Reset value of every output is 0: sdata, sclk, slatch, busy, done, overrun. State goes to IDLE and the shadow register is cleared.
- Reset mid-frame: everything aborts at once. No partial latch pulse is emitted.
- Take load sampled at edge 0 as cycle 0:
  - Cycle 1: busy=1, sdata = bit 0, sclk=0.
  - Bit k: sclk rises at 1+(2k+1)*CLK_DIV and falls at 1+(2k+2)*CLK_DIV.
  - slatch rises at 1+2N*CLK_DIV.
  - busy falls and done pulses at 1+(2N+2)*CLK_DIV.
- CLK_DIV=2, N=25: done at cycle 105.
- Minimum gap between frames: none. Back-to-back loads, each asserted in its predecessor's done cycle, give continuous frames.

## Configuration
- PHVL_SER_PARITY_EN:
  - When defined, an even-parity bit is appended after each word's LSB, so N = 30. The parity bit is the XOR of the word's 5 bits.
  - When undefined, N = 25 and no parity logic exists.
- All timing formulas use N.

## Structure
- Shared package phvl_pkg holds:
  - PHASE_W = 5 and NUM_ELEM = 5.
  - The state encoding (IDLE, SHIFT, LATCH).
  - The frame-length constant derived from the macro.
- One sub-module, phvl_clkdiv: the CLK_DIV tick generator with a synchronous clear, cleared on leaving IDLE.
- The shift FSM stays in phvl_serializer.

## Test plan
1. Reset release, then idle for 20 cycles → all outputs remain 0.
2. CLK_DIV=2, eout5..eout1 = 5'h1F, 5'h00, 5'h15, 5'h0A, 5'h01, load at cycle 0:
   - Expected stream: 11111 00000 10101 01010 00001.
   - busy rises at cycle 1, slatch rises at cycle 101, done pulses at cycle 105.
3. Load again at cycle 50 during test 2 → overrun pulses at cycle 51 and the stream is unchanged.
4. Assert rst at cycle 40 mid-frame → all outputs 0 at once. A new load after release produces a complete frame from bit 0.
5. CLK_DIV=1, two back-to-back loads with 5'h0F/5'h10 patterns, the second load in the first done cycle → two contiguous frames of 53 cycles each.
6. With PHVL_SER_PARITY_EN, eout5=5'h07 and others 5'h00:
   - First word is 00111 with parity 1.
   - N=30 and done at cycle 125.
